// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: FSM state encoding and the
// response record returned to the command stream.
package apb_master_pkg;

    localparam int unsigned RspDataWidth = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_master_state_t;

    typedef struct packed {
        logic [RspDataWidth-1:0] rdata;
        logic                    error;
        logic                    timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_bus.sv
// APB bus bundle shared by the command master, the multiplexer and the
// register slaves.
interface ApbBus #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 32
);
    logic                 PCLK;
    logic                 PRESETn;
    logic [AddrWidth-1:0] PADDR;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [DataWidth-1:0] PWDATA;
    logic [DataWidth-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERROR;

    modport Master (
        output PCLK, PRESETn, PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERROR
    );

    modport Slave (
        input  PCLK, PRESETn, PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERROR
    );

endinterface

// File: rtl/apb_command_master_wait_timer.sv
// Saturating count of consecutive stalled ACCESS cycles; expired_o flags the
// stalled cycle that reaches the limit. A limit of 0 disables expiry.
module apb_wait_timer #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntWidth = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] LastCount =
        (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] MaxCount =
        (TimeoutCycles == 0) ? '1 : CntWidth'(TimeoutCycles);

    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MaxCount)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is judged on the count before this stalled cycle is added.
    assign expired_o = (TimeoutCycles != 0) && enable_i && (count_q == LastCount);

endmodule

// File: rtl/apb_command_master.sv
// APB initiator: one valid/ready command becomes one SETUP/ACCESS transfer,
// with PREADY wait states, a stall timeout and a valid/ready response.
module apb_command_master #(
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [DataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    ApbBus.Master                bus
);
    import apb_master_pkg::*;

    apb_master_state_t    state_q,     state_d;
    logic [AddrWidth-1:0] paddr_q,     paddr_d;
    logic                 pwrite_q,    pwrite_d;
    logic [DataWidth-1:0] pwdata_q,    pwdata_d;
    logic                 psel_q,      psel_d;
    logic                 penable_q,   penable_d;
    logic                 rsp_valid_q, rsp_valid_d;
    apb_rsp_t             rsp_q,       rsp_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign timer_enable = (state_q == ACCESS) && !bus.PREADY;
    assign timer_clear  = (state_q == RESP) && rsp_ready;

    apb_wait_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wait_timer (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A slave completing on the limit cycle takes priority over the timeout.
                if (bus.PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : RspDataWidth'(bus.PRDATA);
                    rsp_d.error   = bus.PSLVERROR;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.error   = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Held low while reset is asserted even though the state already reads IDLE.
    assign cmd_ready   = (state_q == IDLE) && !PRESET;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DataWidth'(rsp_q.rdata);
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;

    assign bus.PCLK    = PCLK;
    assign bus.PRESETn = ~PRESET;
    assign bus.PADDR   = paddr_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_command_master.sv
// Bench for apb_command_master: directed transfers against a configurable
// slave, a cycle-indexed expectation model and literal per-transfer checks.
module tb_apb_command_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 PCLK = ~PCLK;

    ApbBus #(.AddrWidth(AW), .DataWidth(DW)) bus_if ();

    apb_command_master #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .bus        (bus_if)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Slave: PREADY after slv_wait stalled ACCESS cycles, error only with PREADY.
    int unsigned slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    int unsigned acc_cnt   = 0;

    always @(posedge PCLK) begin
        if (bus_if.PSEL && bus_if.PENABLE) acc_cnt <= acc_cnt + 1;
        else                               acc_cnt <= 0;
    end
    assign bus_if.PREADY    = bus_if.PSEL && bus_if.PENABLE && (acc_cnt == slv_wait);
    assign bus_if.PRDATA    = slv_rdata;
    assign bus_if.PSLVERROR = slv_err && bus_if.PREADY;

    // Model: a transfer accepted in cycle t selects the bus in t+1..t+1+alen,
    // enables it in t+2..t+1+alen, and responds from t+2+alen until consumed.
    int unsigned cyc      = 0;
    bit          have_txn = 1'b0;
    int unsigned t_acc    = 0;
    int unsigned alen     = 0;
    logic [15:0] m_addr   = '0;
    logic        m_write  = 1'b0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rdata  = '0;
    logic        m_err    = 1'b0;
    logic        m_to     = 1'b0;

    always @(posedge PCLK) begin
        if (PRESET) begin
            have_txn <= 1'b0;
            m_addr   <= '0;
            m_write  <= 1'b0;
            m_wdata  <= '0;
        end else if (!have_txn) begin
            if (cmd_valid) begin
                have_txn <= 1'b1;
                t_acc    <= cyc;
                m_addr   <= cmd_addr;
                m_write  <= cmd_write;
                m_wdata  <= cmd_wdata;
                alen     <= (slv_wait >= TO) ? TO : slv_wait + 1;
                m_to     <= (slv_wait >= TO);
                m_err    <= (slv_wait >= TO) || slv_err;
                m_rdata  <= (cmd_write || (slv_wait >= TO)) ? 32'h0 : slv_rdata;
            end
        end else if ((cyc >= t_acc + 2 + alen) && rsp_ready) begin
            have_txn <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    bit chk_en = 1'b0;

    always @(negedge PCLK) begin : cmp
        bit e_rdy, e_sel, e_en, e_rv;
        if (chk_en) begin
            e_rdy = !PRESET && !have_txn;
            e_sel = !PRESET && have_txn && (cyc <= t_acc + 1 + alen);
            e_en  = !PRESET && have_txn && (cyc >= t_acc + 2) && (cyc <= t_acc + 1 + alen);
            e_rv  = !PRESET && have_txn && (cyc >= t_acc + 2 + alen);
            chk("m_cmd_ready", cmd_ready, e_rdy);
            chk("m_psel", bus_if.PSEL, e_sel);
            chk("m_penable", bus_if.PENABLE, e_en);
            chk("m_rsp_valid", rsp_valid, e_rv);
            chk("m_presetn", bus_if.PRESETn, !PRESET);
            chk("m_paddr", bus_if.PADDR, PRESET ? 16'h0 : m_addr);
            chk("m_pwrite", bus_if.PWRITE, PRESET ? 1'b0 : m_write);
            chk("m_pwdata", bus_if.PWDATA, PRESET ? 32'h0 : m_wdata);
            if (e_rv || PRESET) begin
                chk("m_rsp_rdata", rsp_rdata, PRESET ? 32'h0 : m_rdata);
                chk("m_rsp_error", rsp_error, PRESET ? 1'b0 : m_err);
                chk("m_rsp_timeout", rsp_timeout, PRESET ? 1'b0 : m_to);
            end
        end
    end

    // Starts at a negedge, returns at the negedge after the response is consumed.
    task automatic do_txn(input string name, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wd, input int unsigned wt, input logic [31:0] rd,
                          input logic er, input bit hold_valid, input int unsigned hold,
                          input int unsigned exp_lat, input logic [31:0] exp_rd,
                          input logic exp_er, input logic exp_to);
        int unsigned lat   = 0;
        int unsigned nsel  = 0;
        int unsigned nen   = 0;
        int unsigned guard = 0;
        bit          seen  = 1'b0;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        slv_wait  = wt;
        slv_rdata = rd;
        slv_err   = er;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        chk({name, "_accept"}, cmd_ready, 1'b1);
        while (lat < 40 && !seen) begin
            @(negedge PCLK);
            lat++;
            if (lat == 1 && !hold_valid) cmd_valid = 1'b0;
            if (bus_if.PSEL)    nsel++;
            if (bus_if.PENABLE) nen++;
            seen = rsp_valid;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_psel_cycles"}, nsel, exp_lat - 1);
        chk({name, "_penable_cycles"}, nen, exp_lat - 2);
        chk({name, "_rdata"}, rsp_rdata, exp_rd);
        chk({name, "_error"}, rsp_error, exp_er);
        chk({name, "_timeout"}, rsp_timeout, exp_to);
        chk({name, "_paddr_hold"}, bus_if.PADDR, addr);
        chk({name, "_pwrite_hold"}, bus_if.PWRITE, wr);
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge PCLK);
            chk({name, "_hold_valid"}, rsp_valid, 1'b1);
            chk({name, "_hold_rdata"}, rsp_rdata, exp_rd);
            chk({name, "_hold_cmd_ready"}, cmd_ready, 1'b0);
            chk({name, "_hold_psel"}, bus_if.PSEL, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk({name, "_consumed"}, rsp_valid, 1'b0);
        chk({name, "_idle_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        PRESET    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        #1 PRESET = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_psel", bus_if.PSEL, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_presetn", bus_if.PRESETn, 1'b0);
        chk("rst_paddr", bus_if.PADDR, 16'h0);
        #2 PRESET = 1'b0;
        @(negedge PCLK);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        do_txn("wr0", 1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 1'b0, 0,
               3, 32'h0, 1'b0, 1'b0);
        do_txn("rd_wait3", 1'b0, 16'h0020, 32'h0, 3, 32'h12345678, 1'b0, 1'b0, 0,
               6, 32'h12345678, 1'b0, 1'b0);
        do_txn("rd_slverr", 1'b0, 16'h0030, 32'h0, 1, 32'hAAAA5555, 1'b1, 1'b0, 0,
               4, 32'hAAAA5555, 1'b1, 1'b0);
        do_txn("rd_timeout", 1'b0, 16'h0040, 32'h0, 100, 32'h11112222, 1'b0, 1'b0, 0,
               6, 32'h0, 1'b1, 1'b1);
        do_txn("rd_ready_at_limit", 1'b0, 16'h0044, 32'h0, 3, 32'h33334444, 1'b0, 1'b0, 0,
               6, 32'h33334444, 1'b0, 1'b0);
        do_txn("wr_backpressure", 1'b1, 16'h0050, 32'h0BADF00D, 0, 32'h0, 1'b0, 1'b1, 5,
               3, 32'h0, 1'b0, 1'b0);
        do_txn("rd_after_bp", 1'b0, 16'h0054, 32'h0, 0, 32'h5555AAAA, 1'b0, 1'b0, 0,
               3, 32'h5555AAAA, 1'b0, 1'b0);

        cmd_write = 1'b0;
        cmd_addr  = 16'h0070;
        slv_wait  = 3;
        slv_rdata = 32'h77778888;
        slv_err   = 1'b0;
        cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("mid_rst_in_access", bus_if.PENABLE, 1'b1);
        #2 PRESET = 1'b1;
        #1;
        chk("mid_rst_psel", bus_if.PSEL, 1'b0);
        chk("mid_rst_penable", bus_if.PENABLE, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_presetn", bus_if.PRESETn, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge PCLK);
        #2 PRESET = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge PCLK);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        do_txn("wr_after_rst", 1'b1, 16'h0060, 32'h01234567, 2, 32'h0, 1'b0, 1'b0, 0,
               5, 32'h0, 1'b0, 1'b0);

        repeat (3) @(negedge PCLK);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

endmodule
